soc_network_adapter_config_fetch: RTL and testbench
===================================================

# soc_network_adapter_config_fetch

Boot-time AHB-Lite master that reads the network adapter configuration register space of a tile and caches the values for local consumers such as the boot ROM helper, the DMA setup logic and the debug bridge. On a `start` pulse it issues a fixed sequence of single read transfers: tile ID, tile count, configuration bits, core base, compute-tile count, and then the compute-tile list. The results are held in registers. It sits between tile control logic and the configuration slave port on the tile-local bus.

## Interface
Parameters:
- `XLEN`, 32, data bus width; only 32 is supported.
- `MAX_CTS`, 64, capacity of the compute-tile list cache; 1..64.
- `BASE`, 16'h0000, byte base address of the configuration register space.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request to begin a fetch; ignored unless idle.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`/`error`.
- `done`  out  1  one-cycle pulse when the sequence completes without error.
- `error`  out  1  one-cycle pulse on an aborted sequence (`hresp`).
- `valid`  out  1  cached values are coherent; cleared on `start`, set with `done`.
- `tile_id`, `num_tiles`, `conf`, `core_base`, `num_cts`  out  32 each  cached register values.
- `ct_idx`  in  6  compute-tile list lookup index.
- `ct_id`  out  16  list entry at `ct_idx`, combinational; 0 if `ct_idx >= min(num_cts, MAX_CTS)`.
- `hsel`, `htrans[1:0]`, `haddr[15:0]`, `hwrite`, `hsize[2:0]`, `hburst[2:0]`, `hprot[3:0]`, `hmastlock`, `hwdata[31:0]`  out  AHB-Lite master request.
- `hrdata`  in  32  read data.
- `hready`  in  1  transfer ready.
- `hresp`  in  1  error response.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE, ERR.
- IDLE:
  - `start=1` clears `valid`, sets step=0, and moves to ADDR.
- ADDR:
  - Drives `hsel=1`, `htrans=2'b10` (NONSEQ) and `haddr=BASE+offset(step)`.
  - Moves to DATA when `hready=1`; otherwise holds.
- DATA:
  - Drives `hsel=0` and `htrans=2'b00`.
  - `hresp=1` moves to ERR; this takes priority and does not wait for `hready`.
  - Otherwise `hready=1` captures `hrdata` into the step's target, then:
    - increments step and returns to ADDR if steps remain;
    - otherwise moves to DONE.
  - `hready=0` holds.
- DONE:
  - Pulses `done`, sets `valid`, and moves to IDLE.
- ERR:
  - Pulses `error`, leaves `valid=0`, and moves to IDLE.
  - Cached registers keep whatever was captured before the abort.
- Step offsets 0..4: 0x00 `tile_id`, 0x04 `num_tiles`, 0x0C `conf`, 0x10 `core_base`, 0x28 `num_cts`.
- List steps:
  - Entry j (0 ≤ j < N, N = min(captured `num_cts`, MAX_CTS)) is read from offset 0x200 + 2*j.
  - Even j captures `hrdata[31:16]`; odd j captures `hrdata[15:0]`.
  - N is evaluated from the value captured at step 4; N=0 goes straight from step 4 to DONE.
- Fixed request fields:
  - `hwrite=0`, `hsize=3'b010`, `hburst=3'b000`, `hprot=4'b0011`, `hmastlock=0`, `hwdata=0`.
  - `haddr[1:0]` may be 2'b10 for odd list entries. This halfword-select encoding is required by the slave even though `hsize` stays word.

## Timing
- Reset values:
  - FSM is in IDLE.
  - `busy`, `done`, `error`, `valid` = 0.
  - All cached registers and list entries = 0.
  - `hsel=0`, `htrans=0`, `haddr=0`.
- Zero-wait-state latency, with `start` sampled in cycle T:
  - Transfer k is in ADDR at T+1+2k and in DATA at T+2+2k.
  - `done` is high at T+2*(5+N)+1.
  - `busy` is high from T+1 through T+2*(5+N).
- Each wait cycle (`hready=0`) in ADDR or DATA adds exactly one cycle.
- Only one transfer is outstanding; there is no address/data pipelining.
- Captured values update on the clock edge that ends the DATA cycle.
- `start` while busy, or in the DONE/ERR cycle, is ignored.
- `rst` mid-sequence returns to IDLE on the next edge with reset values and no `done`/`error` pulse.

## Configuration
- Macro: `SOC_NA_CONFIG_FETCH_CTLIST_EN`.
- Defined:
  - The list steps are performed.
  - The MAX_CTS×16 entry cache is instantiated.
- Undefined:
  - The sequence ends after step 4 (`done` at T+11 with zero waits).
  - No list cache exists and `ct_id` is constant 0.
  - `num_cts` is still fetched.

## Test plan
- Zero waits; slave returns tile_id=3, num_tiles=4, conf=0x3, core_base=6, num_cts=2, word 0x200=0x0005_0007:
  - `done` at T+15;
  - `ct_id(0)`=0x0005, `ct_id(1)`=0x0007, `ct_id(2)`=0;
  - `valid`=1.
- Same configuration with `hready` low for 2 cycles in ADDR of step 1 and 1 cycle in DATA of step 3 -> `done` at T+18; identical captured values.
- `hresp=1` in DATA of step 2 -> `error` pulse at the following cycle, `valid`=0, `tile_id`=3, `conf`=0, no further `htrans` NONSEQ.
- num_cts=0 -> exactly 5 transfers, `done` at T+11.
- num_cts=100 with MAX_CTS=64 -> 64 list reads, last address 0x27E.
- `rst` asserted at T+6 -> all outputs return to reset values at T+7; a new `start` then completes normally.

Source files
------------

// File: rtl/soc_network_adapter_config_fetch.sv
// Boot-time AHB-Lite master that reads the network adapter configuration
// space of a tile and holds the values for local consumers.
//
// A start pulse issues single word reads, one at a time: tile ID, tile
// count, config bits, core base, compute-tile count, then (optionally) the
// compute-tile list, one 16-bit entry per read.
//
// Build option: define SOC_NA_CONFIG_FETCH_CTLIST_EN to fetch and cache the
// compute-tile list. When it is undefined the sequence stops after num_cts
// and ct_id is constant 0.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begin a fetch (only accepted when idle)
//   busy/done/error    sequence status; done/error are one-cycle pulses
//   valid              cached values are coherent
//   tile_id .. num_cts cached register values
//   ct_idx / ct_id     combinational compute-tile list lookup
//   h*                 AHB-Lite master request/response
module soc_network_adapter_config_fetch #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MAX_CTS = 64,
    parameter logic [15:0] BASE    = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            valid,
    output logic [XLEN-1:0] tile_id,
    output logic [XLEN-1:0] num_tiles,
    output logic [XLEN-1:0] conf,
    output logic [XLEN-1:0] core_base,
    output logic [XLEN-1:0] num_cts,
    input  logic [5:0]      ct_idx,
    output logic [15:0]     ct_id,
    output logic            hsel,
    output logic [1:0]      htrans,
    output logic [15:0]     haddr,
    output logic            hwrite,
    output logic [2:0]      hsize,
    output logic [2:0]      hburst,
    output logic [3:0]      hprot,
    output logic            hmastlock,
    output logic [XLEN-1:0] hwdata,
    input  logic [XLEN-1:0] hrdata,
    input  logic            hready,
    input  logic            hresp
);

    // Step counter covers 5 fixed registers plus up to 64 list entries.
    localparam int unsigned STEP_W = 7;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [STEP_W-1:0] step;
    logic [STEP_W-1:0] step_nx;
    logic              capture_c;
    logic              last_c;

    // Byte offset of the register read at a given step.
    function automatic logic [15:0] offset(input logic [STEP_W-1:0] s);
        logic [STEP_W-1:0] j;
        j = s - STEP_W'(5);
        case (s)
            STEP_W'(0): return 16'h0000;
            STEP_W'(1): return 16'h0004;
            STEP_W'(2): return 16'h000C;
            STEP_W'(3): return 16'h0010;
            STEP_W'(4): return 16'h0028;
            default:    return 16'h0200 + {8'd0, j, 1'b0};
        endcase
    endfunction

    // Fixed request fields: single word reads, data/privileged, unlocked.
    assign hwrite    = 1'b0;
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;
    assign hwdata    = '0;

    // Next-state logic.
    always_comb begin
        state_nx  = state;
        step_nx   = step;
        capture_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ADDR;
                    step_nx  = '0;
                end
            end
            S_ADDR: begin
                if (hready) begin
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                // Error response aborts without waiting for hready.
                if (hresp) begin
                    state_nx = S_ERR;
                end else if (hready) begin
                    capture_c = 1'b1;
                    if (last_c) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ADDR;
                        step_nx  = step + STEP_W'(1);
                    end
                end
            end
            S_DONE:  state_nx = S_IDLE;
            S_ERR:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, registered status/bus outputs and fixed-register captures.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            step      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            valid     <= 1'b0;
            hsel      <= 1'b0;
            htrans    <= 2'b00;
            haddr     <= '0;
            tile_id   <= '0;
            num_tiles <= '0;
            conf      <= '0;
            core_base <= '0;
            num_cts   <= '0;
        end else begin
            state  <= state_nx;
            step   <= step_nx;
            busy   <= (state_nx == S_ADDR) || (state_nx == S_DATA);
            done   <= (state_nx == S_DONE);
            error  <= (state_nx == S_ERR);
            hsel   <= (state_nx == S_ADDR);
            htrans <= (state_nx == S_ADDR) ? 2'b10 : 2'b00;
            if (state_nx == S_ADDR) begin
                haddr <= BASE + offset(step_nx);
            end
            if ((state == S_IDLE) && start) begin
                valid <= 1'b0;
            end else if (state_nx == S_DONE) begin
                valid <= 1'b1;
            end
            if (capture_c) begin
                case (step)
                    STEP_W'(0): tile_id   <= hrdata;
                    STEP_W'(1): num_tiles <= hrdata;
                    STEP_W'(2): conf      <= hrdata;
                    STEP_W'(3): core_base <= hrdata;
                    STEP_W'(4): num_cts   <= hrdata;
                    default: ;
                endcase
            end
        end
    end

`ifdef SOC_NA_CONFIG_FETCH_CTLIST_EN
    localparam int unsigned IDX_W = (MAX_CTS > 1) ? $clog2(MAX_CTS) : 1;

    logic [15:0]       ct_mem [MAX_CTS];
    logic [STEP_W-1:0] list_j_c;
    logic [STEP_W-1:0] n_reg_c;
    logic [STEP_W-1:0] n_list_c;

    // List length clamped to the cache capacity.
    function automatic logic [STEP_W-1:0] clamp_n(input logic [XLEN-1:0] v);
        if (v >= XLEN'(MAX_CTS)) begin
            return STEP_W'(MAX_CTS);
        end
        return v[STEP_W-1:0];
    endfunction

    assign list_j_c = step - STEP_W'(5);
    assign n_reg_c  = clamp_n(num_cts);
    // At step 4 the count is still on hrdata, not yet in num_cts.
    assign n_list_c = (step == STEP_W'(4)) ? clamp_n(hrdata) : n_reg_c;
    assign last_c   = (step == STEP_W'(4) + n_list_c);

    // Even entries sit in the upper halfword, odd entries in the lower.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(MAX_CTS); i++) begin
                ct_mem[i] <= '0;
            end
        end else if (capture_c && (step >= STEP_W'(5))) begin
            ct_mem[IDX_W'(list_j_c)] <= list_j_c[0] ? hrdata[15:0] : hrdata[31:16];
        end
    end

    assign ct_id = ({1'b0, ct_idx} < n_reg_c) ? ct_mem[IDX_W'(ct_idx)] : 16'h0000;
`else
    logic [STEP_W-1:0] list_unused;

    assign last_c      = (step == STEP_W'(4));
    assign ct_id       = 16'h0000;
    // List-only inputs have no function in this build.
    assign list_unused = STEP_W'(MAX_CTS) ^ {1'b0, ct_idx};
`endif

endmodule

// File: tb/tb_soc_network_adapter_config_fetch.sv
// Scoreboard bench for soc_network_adapter_config_fetch: a driver issues
// fetches and queues expected results, an AHB slave model answers with
// configurable wait states/errors, and a monitor checks the DUT outputs.
module tb_soc_network_adapter_config_fetch;

    localparam int K_SNAP = 0;
    localparam int K_BUSY = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;
    localparam int MAXC   = 64;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        start  = 1'b0;
    logic [5:0]  ct_idx = '0;
    logic        hready = 1'b1;
    logic        hresp  = 1'b0;
    logic [31:0] hrdata = '0;
    logic        busy, done, error, valid, hsel, hwrite, hmastlock;
    logic [31:0] tile_id, num_tiles, conf, core_base, num_cts, hwdata;
    logic [15:0] ct_id, haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    soc_network_adapter_config_fetch dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .valid(valid), .tile_id(tile_id), .num_tiles(num_tiles),
        .conf(conf), .core_base(core_base), .num_cts(num_cts), .ct_idx(ct_idx),
        .ct_id(ct_id), .hsel(hsel), .htrans(htrans), .haddr(haddr),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwdata(hwdata), .hrdata(hrdata),
        .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] tile_id, num_tiles, conf, core_base, num_cts;
        logic [5:0]  i0, i1, i2;
        logic [15:0] ct0, ct1, ct2;
        int          xfers;
        int          xbase;
        logic [15:0] last_addr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Slave configuration (driver-owned).
    int          aw[128];
    int          dw[128];
    int          err_idx   = -1;
    int          xbase     = 0;
    int          list_mode = 0;
    logic [31:0] cfg_ncts  = '0;

    // Slave state (slave-owned).
    int          xfer_cnt  = 0;
    int          cur       = 0;
    int          wleft     = 0;
    int          ph        = 0;
    logic        last_rdy  = 1'b1;
    logic [15:0] last_addr = '0;
    logic [15:0] cur_addr  = '0;

    function automatic logic [31:0] rd(input logic [15:0] a);
        logic [15:0] w;
        int          wi;
        w = a & 16'hFFFC;
        case (w)
            16'h0000: return 32'd3;
            16'h0004: return 32'd4;
            16'h000C: return 32'h3;
            16'h0010: return 32'd6;
            16'h0028: return cfg_ncts;
            default: ;
        endcase
        if (w >= 16'h0200) begin
            wi = (int'(w) - 32'h200) >> 2;
            if (list_mode == 1) return {16'(32'h1000 + 2 * wi), 16'(32'h1000 + 2 * wi + 1)};
            if (w == 16'h0200) return 32'h0005_0007;
        end
        return 32'hDEAD_BEEF;
    endfunction

    // AHB slave: decides hready/hresp/hrdata for the next edge.
    always @(negedge clk) begin
        if (rst) begin
            ph = 0; hready = 1'b1; hresp = 1'b0;
        end else if (hsel && htrans == 2'b10) begin
            if (!(ph == 1 && !last_rdy)) begin
                cur = xfer_cnt - xbase;
                xfer_cnt++;
                wleft = (cur >= 0 && cur < 128) ? aw[cur] : 0;
                last_addr = haddr;
                cur_addr  = haddr;
            end
            ph = 1; hresp = 1'b0;
            if (wleft > 0) begin hready = 1'b0; wleft--; end
            else hready = 1'b1;
        end else if ((ph == 1 && last_rdy) || (ph == 2 && !last_rdy)) begin
            if (ph == 1) wleft = (cur >= 0 && cur < 128) ? dw[cur] : 0;
            ph = 2;
            if (wleft > 0) begin
                hready = 1'b0; hresp = 1'b0; wleft--;
            end else begin
                hready = 1'b1; hrdata = rd(cur_addr); hresp = (cur == err_idx);
            end
        end else begin
            ph = 0; hready = 1'b1; hresp = 1'b0;
        end
        last_rdy = hready;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: timed snapshots and completion pulses against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].kind <= K_BUSY && cyc >= sb[0].cyc) begin
            e = sb.pop_front();
            if (e.kind == K_SNAP) begin
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
                chk("rst_error", 32'(error), 0);
                chk("rst_valid", 32'(valid), 0);
                chk("rst_tile_id", tile_id, 0);
                chk("rst_num_tiles", num_tiles, 0);
                chk("rst_conf", conf, 0);
                chk("rst_core_base", core_base, 0);
                chk("rst_num_cts", num_cts, 0);
                chk("rst_hsel", 32'(hsel), 0);
                chk("rst_htrans", 32'(htrans), 0);
                chk("rst_haddr", 32'(haddr), 0);
            end else begin
                chk("start_busy", 32'(busy), 1);
                chk("start_valid_cleared", 32'(valid), 0);
                chk("start_hsel", 32'(hsel), 1);
                chk("start_htrans", 32'(htrans), 32'h2);
                chk("start_haddr", 32'(haddr), 0);
            end
        end
        if (!rst && (done || error)) begin
            if (sb.size() == 0 || sb[0].kind < K_DONE) begin
                chk("unexpected_pulse", 32'({done, error}), 0);
            end else begin
                e = sb.pop_front();
                chk("end_cycle", 32'(cyc), 32'(e.cyc));
                chk("done_pulse", 32'(done), 32'(e.kind == K_DONE));
                chk("error_pulse", 32'(error), 32'(e.kind == K_ERR));
                chk("valid", 32'(valid), 32'(e.kind == K_DONE));
                chk("busy_end", 32'(busy), 0);
                chk("tile_id", tile_id, e.tile_id);
                chk("num_tiles", num_tiles, e.num_tiles);
                chk("conf", conf, e.conf);
                chk("core_base", core_base, e.core_base);
                chk("num_cts", num_cts, e.num_cts);
                chk("xfers", 32'(xfer_cnt - e.xbase), 32'(e.xfers));
                chk("last_addr", 32'(last_addr), 32'(e.last_addr));
                ct_idx = e.i0; #1;
                chk("ct_id_a", 32'(ct_id), 32'(e.ct0));
                ct_idx = e.i1; #1;
                chk("ct_id_b", 32'(ct_id), 32'(e.ct1));
                ct_idx = e.i2; #1;
                chk("ct_id_c", 32'(ct_id), 32'(e.ct2));
            end
        end else if (sb.size() > 0 && sb[0].kind >= K_DONE && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            chk("end_timeout", 32'(cyc), 32'(e.cyc));
        end
    end

    function automatic logic [15:0] exp_addr(input int k);
        case (k)
            0: return 16'h0000;
            1: return 16'h0004;
            2: return 16'h000C;
            3: return 16'h0010;
            4: return 16'h0028;
            default: return 16'(32'h200 + 2 * (k - 5));
        endcase
    endfunction

    function automatic int list_len(input logic [31:0] v);
`ifdef SOC_NA_CONFIG_FETCH_CTLIST_EN
        return (v >= 32'(MAXC)) ? MAXC : int'(v);
`else
        return (v == v) ? 0 : 0;
`endif
    endfunction

    function automatic logic [15:0] exp_ct(input int lmode, input int n, input logic [5:0] i);
        if (int'(i) >= n) return 16'h0;
        if (lmode == 1) return 16'(32'h1000 + int'(i));
        if (i == 6'd0) return 16'h0005;
        if (i == 6'd1) return 16'h0007;
        return 16'h0;
    endfunction

    task automatic wait_empty();
        for (int i = 0; i < 1000 && sb.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
    endtask

    task automatic run(input logic [31:0] ncts, input int lmode, input int err_at,
                       input int aw1, input int dw3,
                       input logic [31:0] x_tile, input logic [31:0] x_ntiles,
                       input logic [31:0] x_conf, input logic [31:0] x_core,
                       input logic [31:0] x_ncts,
                       input logic [5:0] i0, input logic [5:0] i1, input logic [5:0] i2);
        exp_t b, c;
        int   t, nx, nr;
        b = '{default: 0};
        c = '{default: 0};
        for (int i = 0; i < 128; i++) begin aw[i] = 0; dw[i] = 0; end
        aw[1] = aw1; dw[3] = dw3; err_idx = err_at;
        cfg_ncts = ncts; list_mode = lmode;
        @(posedge clk); #1;
        start = 1'b1; t = cyc; xbase = xfer_cnt;
        nx = (err_at >= 0) ? err_at + 1 : 5 + list_len(ncts);
        nr = list_len(x_ncts);
        b.kind = K_BUSY; b.cyc = t + 1;
        c.kind = (err_at >= 0) ? K_ERR : K_DONE;
        c.cyc = t + 2 * nx + 1 + aw1 + dw3;
        c.tile_id = x_tile; c.num_tiles = x_ntiles; c.conf = x_conf;
        c.core_base = x_core; c.num_cts = x_ncts;
        c.i0 = i0; c.i1 = i1; c.i2 = i2;
        c.ct0 = exp_ct(lmode, nr, i0);
        c.ct1 = exp_ct(lmode, nr, i1);
        c.ct2 = exp_ct(lmode, nr, i2);
        c.xfers = nx; c.xbase = xbase; c.last_addr = exp_addr(nx - 1);
        sb.push_back(b);
        sb.push_back(c);
        @(posedge clk); #1;
        start = 1'b0;
        wait_empty();
    endtask

    initial begin
        exp_t s;
        int   t;
        s = '{default: 0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        s.kind = K_SNAP; s.cyc = cyc;
        sb.push_back(s);
        wait_empty();

        // Error response in DATA of step 2, from reset state.
        run(32'd2, 0, 2, 0, 0, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 6'd0, 6'd1, 6'd2);
        // Zero waits, two list entries.
        run(32'd2, 0, -1, 0, 0, 32'd3, 32'd4, 32'd3, 32'd6, 32'd2, 6'd0, 6'd1, 6'd2);
        // Wait states: 2 in ADDR of step 1, 1 in DATA of step 3.
        run(32'd2, 0, -1, 2, 1, 32'd3, 32'd4, 32'd3, 32'd6, 32'd2, 6'd0, 6'd1, 6'd2);
        // Empty list.
        run(32'd0, 0, -1, 0, 0, 32'd3, 32'd4, 32'd3, 32'd6, 32'd0, 6'd0, 6'd1, 6'd2);
        // List longer than the cache.
        run(32'd100, 1, -1, 0, 0, 32'd3, 32'd4, 32'd3, 32'd6, 32'd100, 6'd0, 6'd63, 6'd5);

        // Reset in the middle of a fetch.
        for (int i = 0; i < 128; i++) begin aw[i] = 0; dw[i] = 0; end
        err_idx = -1; cfg_ncts = 32'd2; list_mode = 0;
        @(posedge clk); #1;
        start = 1'b1; t = cyc; xbase = xfer_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < t + 6) begin @(posedge clk); #1; end
        rst = 1'b1;
        s.kind = K_SNAP; s.cyc = t + 7;
        sb.push_back(s);
        @(posedge clk); #1;
        rst = 1'b0;
        wait_empty();
        repeat (3) @(posedge clk);
        run(32'd2, 0, -1, 0, 0, 32'd3, 32'd4, 32'd3, 32'd6, 32'd2, 6'd0, 6'd1, 6'd2);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
